mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Shares one synchronous single-port RAM between NREQ bus masters, e.g. two proc instances, or a proc plus a program-loader/DMA master.
- Each master issues single-beat read or write commands with a req/gnt handshake.
- Arbitration is round-robin. An optional lock lets one master keep the RAM for read-modify-write sequences, bounded by a watchdog.
- Read data returns with fixed 2-cycle latency after grant, tagged to the owning master.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 16, address width.
- DW, 16, data width.
- MAX_LOCK, 16, maximum consecutive locked grants before forced release (≥2).

Ports:
- Clock  in  1  system clock, all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-master command request.
- lock  in  NREQ  per-master request to retain ownership after the current grant.
- we  in  NREQ  per-master write enable (1 = write, 0 = read).
- addr  in  NREQ*AW  flattened addresses; master i at [i*AW +: AW].
- wdata  in  NREQ*DW  flattened write data.
- gnt  out  NREQ  one-hot grant, combinational in the request cycle.
- rvalid  out  NREQ  one-hot read-data-valid.
- rdata  out  DW  read data, broadcast to all masters, qualified by rvalid.
- mem_addr  out  AW  registered RAM address.
- mem_wdata  out  DW  registered RAM write data.
- mem_wr  out  1  registered RAM write strobe.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after mem_addr is presented.

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - gnt = 0, rvalid = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
  - rr_ptr = 0, so master 0 has highest priority.
  - State = IDLE, lock_cnt = 0, read pipeline cleared.
  - Reads in flight are dropped: no rvalid after reset.
- Handshake:
  - A command transfers in cycle N iff req[i] && gnt[i].
  - At most one gnt bit is set per cycle.
  - A master holds req/we/addr/wdata stable until granted.
  - Deasserting req before grant withdraws the request and is legal.
- Round-robin: the search starts at rr_ptr and wraps modulo NREQ. After an unlocked grant to i, rr_ptr <= (i+1) mod NREQ. With no request, rr_ptr is unchanged.
- Command path: at the posedge ending cycle N, mem_addr/mem_wdata <= the granted master's fields and mem_wr <= we[i]. With no grant, mem_wr <= 0 and mem_addr/mem_wdata hold their values.
- Read return:
  - A granted read in cycle N gives rvalid[i] = 1 and rdata = mem_rdata in cycle N+2.
  - The owner tag and read flag travel through a 2-stage registered pipeline.
  - Writes never produce rvalid.
  - Back-to-back reads from different masters return in grant order, one per cycle.
- FSM states:
  - IDLE: no owner; next state OPEN or LOCKED per the grant.
  - OPEN: normal RR grant each cycle; next state LOCKED if the granted master asserts lock.
  - LOCKED: owner o only. gnt = req[o]; other requests are masked; rr_ptr is frozen.
    - lock_cnt increments on each granted cycle.
    - Exit when lock[o] = 0 → OPEN, with rr_ptr <= o+1.
    - Exit when lock_cnt reaches MAX_LOCK-1 on a grant (forced release) → OPEN, with rr_ptr <= o+1 and lock_cnt <= 0. In the next cycle o is treated as unlocked and lowest priority.
  - Entering LOCKED sets lock_cnt <= 0, and that entering grant counts as the first locked grant.
- Owner idle while locked: if req[o] = 0 with lock[o] = 1, the owner stays locked, no grant is issued, and lock_cnt does not advance.
- Out-of-range lock: a lock bit on a non-granted master has no effect.
- A write and a read may be granted in consecutive cycles. The RAM sees them in order, giving read-after-write coherence at the RAM.

Decomposition:
- Shared package: state encoding (IDLE/OPEN/LOCKED) and a clog2-based index width constant for NREQ.
- Sub-module rr_pick:
  - Combinational rotate / priority-encode / unrotate.
  - Inputs: request vector, pointer. Outputs: one-hot grant, index.
- Lock FSM, lock counter, command registers and the read tag pipeline stay in mem_rr_arbiter.

Test Plan:
- Reset mid-read: grant a read to master 1, assert Reset in cycle N+1 → rvalid stays 0 for N+1..N+3; mem_wr = 0 and mem_addr = 0 after reset.
- Fairness: NREQ=2, both req held high with reads to 0x0010 / 0x0020 → gnt alternates 01,10,01,10. rvalid alternates matching, 2 cycles after each grant; rdata equals the RAM model contents.
- Write then read: master 0 writes 0xBEEF to 0x0100, master 1 then reads 0x0100 → master 1 gets rvalid with rdata = 0xBEEF; no rvalid for the write.
- Lock hold: master 0 locks with req every cycle while master 1 requests → master 0 gets 3 consecutive grants. Dropping lock hands the next grant to master 1.
- Watchdog: MAX_LOCK=4, master 0 holds lock+req indefinitely while master 1 requests → grant pattern is 0,0,0,0,1, then master 0 relocks.
- Withdrawal and idle: master 1 drops req before grant → no gnt to it. With all req = 0 → gnt = 0, mem_wr = 0, rr_ptr unchanged.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin RAM arbiter.
package mem_rr_arbiter_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_LOCKED
  } arb_state_t;

  // Requester index plus one, wrapping at n.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i,
                                               input int unsigned n);
    return ((32'(i) + 32'd1) >= n) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Round-robin picker: rotate requests to start at ptr, take the lowest set
// bit, rotate the winner back to an absolute index and one-hot grant.
module mem_rr_arbiter_rr_pick
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [NREQ-1:0] rot;
  int unsigned     pos;

  always_comb begin
    rot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (pos == j) rot[k] = req[j];
      end
    end
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        idx   = (32'(ptr) + k >= NREQ) ? IDX_W'(32'(ptr) + k - NREQ)
                                       : IDX_W'(32'(ptr) + k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      gnt[j] = valid && (IDX_W'(j) == idx);
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NREQ
// masters, with bounded lock ownership and a 2-stage read-return tag pipe.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic [NREQ-1:0]  we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_wr,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int unsigned CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             forced_q, forced_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  logic [NREQ-1:0]  lock_eff;
  logic             owner_req, owner_lock, pick_lock;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_we;

  logic             rd_v1, rd_v2;
  logic [IDX_W-1:0] rd_tag1, rd_tag2;

  mem_rr_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // A master released by the watchdog may not relock in the very next cycle.
  always_comb begin
    lock_eff   = lock;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    pick_lock  = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (forced_q && IDX_W'(j) == owner_q) lock_eff[j] = 1'b0;
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (IDX_W'(j) == owner_q) begin
        owner_req  = req[j];
        owner_lock = lock[j];
      end
      if (IDX_W'(j) == pick_idx) pick_lock = pick_gnt[j] && lock_eff[j];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    forced_d   = 1'b0;
    grant_idx  = pick_idx;
    grant_any  = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        grant_idx = owner_q;
        grant_any = owner_req;
        if (owner_req) begin
          if (!owner_lock) begin
            state_d    = ST_OPEN;
            rr_ptr_d   = idx_inc(owner_q, NREQ);
            lock_cnt_d = '0;
          end else if (lock_cnt_q == CW'(MAX_LOCK - 2)) begin
            // This grant is the MAX_LOCK-th of the lock: counter hits MAX_LOCK-1.
            state_d    = ST_OPEN;
            rr_ptr_d   = idx_inc(owner_q, NREQ);
            lock_cnt_d = '0;
            forced_d   = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else if (!owner_lock) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = idx_inc(owner_q, NREQ);
          lock_cnt_d = '0;
        end
      end
      default: begin
        grant_any = pick_valid;
        if (pick_valid) begin
          if (pick_lock) begin
            state_d    = ST_LOCKED;
            owner_d    = pick_idx;
            lock_cnt_d = '0;
          end else begin
            state_d  = ST_OPEN;
            rr_ptr_d = idx_inc(pick_idx, NREQ);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt       = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (IDX_W'(j) == grant_idx) begin
        gnt[j]    = grant_any && !Reset;
        sel_addr  = addr[j*AW +: AW];
        sel_wdata = wdata[j*DW +: DW];
        sel_we    = we[j];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      forced_q   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      rd_tag1    <= '0;
      rd_tag2    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      forced_q   <= forced_d;
      mem_wr     <= grant_any && sel_we;
      if (grant_any) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      rd_v1   <= grant_any && !sel_we;
      rd_tag1 <= grant_idx;
      rd_v2   <= rd_v1;
      rd_tag2 <= rd_tag1;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      rvalid[j] = rd_v2 && (IDX_W'(j) == rd_tag2);
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus a randomized
// run against a queue-based behavioural model of arbitration and read return.
module tb_mem_rr_arbiter;

  localparam int unsigned NREQ     = 2;
  localparam int unsigned AW       = 16;
  localparam int unsigned DW       = 16;
  localparam int unsigned MAX_LOCK = 4;

  logic                 Clock = 1'b0;
  logic                 Reset = 1'b1;
  logic [NREQ-1:0]      req   = '0;
  logic [NREQ-1:0]      lock  = '0;
  logic [NREQ-1:0]      we    = '0;
  logic [NREQ*AW-1:0]   addr  = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_wr;
  logic [DW-1:0]        mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  mem_rr_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .DW       (DW),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic set_cmd(input int m, input logic r, input logic l, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[m]             = r;
    lock[m]            = l;
    we[m]              = w;
    addr[m*AW +: AW]   = a;
    wdata[m*DW +: DW]  = d;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    set_cmd(0, 1, 0, 1, 16'h0040, 16'h1111);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL reset_pre_gnt got=%b want=01", gnt); end
    tick;
    set_cmd(0, 1, 0, 0, 16'h0041, 16'h0);
    set_cmd(1, 1, 0, 0, 16'h0042, 16'h0);
    Reset = 1'b1;
    @(negedge Clock);
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt_masked got=%b want=00", gnt); end
    tick;
    Reset = 1'b0;
    set_cmd(0, 0, 0, 0, 16'h0, 16'h0);
    set_cmd(1, 0, 0, 0, 16'h0, 16'h0);
    @(negedge Clock);
    total++;
    if (mem_wr !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rvalid !== 2'b00) begin
      bad++;
      $display("FAIL reset_regs got wr=%b addr=%h wd=%h rv=%b want 0/0000/0000/00",
               mem_wr, mem_addr, mem_wdata, rvalid);
    end
    tick;
    set_cmd(0, 1, 0, 0, 16'h0050, 16'h0);
    set_cmd(1, 1, 0, 0, 16'h0060, 16'h0);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL reset_ptr got=%b want=01", gnt); end
    tick;

    // Read to master 1, then reset in the following cycle.
    do_reset;
    set_cmd(1, 1, 0, 0, 16'h0030, 16'h0);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL midread_gnt got=%b want=10", gnt); end
    tick;
    set_cmd(1, 0, 0, 0, 16'h0, 16'h0);
    Reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      total++;
      if (rvalid !== 2'b00) begin bad++; $display("FAIL midread_rvalid N+%0d got=%b want=00", c, rvalid); end
      if (c >= 2) begin
        total++;
        if (mem_wr !== 1'b0 || mem_addr !== 16'h0) begin
          bad++;
          $display("FAIL midread_mem N+%0d got wr=%b addr=%h want 0/0000", c, mem_wr, mem_addr);
        end
      end
      tick;
      Reset = 1'b0;
    end
  endtask

  task automatic test_fairness;
    logic [NREQ-1:0] eg, er;
    logic [DW-1:0]   ed;
    do_reset;
    set_cmd(0, 1, 0, 0, 16'h0010, 16'h0);
    set_cmd(1, 1, 0, 0, 16'h0020, 16'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clock);
      eg = ((c - 1) % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (gnt !== eg) begin bad++; $display("FAIL fair_gnt c=%0d got=%b want=%b", c, gnt, eg); end
      if (c >= 3) begin
        er = ((c - 3) % 2 == 0) ? 2'b01 : 2'b10;
        ed = er[0] ? init_val(16'h0010) : init_val(16'h0020);
        total++;
        if (rvalid !== er || rdata !== ed) begin
          bad++;
          $display("FAIL fair_read c=%0d got rv=%b rd=%h want rv=%b rd=%h", c, rvalid, rdata, er, ed);
        end
      end else begin
        total++;
        if (rvalid !== 2'b00) begin bad++; $display("FAIL fair_early_rv c=%0d got=%b want=00", c, rvalid); end
      end
      tick;
    end
  endtask

  task automatic test_write_then_read;
    do_reset;
    set_cmd(0, 1, 0, 1, 16'h0100, 16'hBEEF);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b want=01", gnt); end
    tick;
    set_cmd(0, 0, 0, 0, 16'h0, 16'h0);
    set_cmd(1, 1, 0, 0, 16'h0100, 16'h0);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b10 || mem_wr !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL rd_gnt_cmd got gnt=%b wr=%b addr=%h wd=%h want 10/1/0100/beef",
               gnt, mem_wr, mem_addr, mem_wdata);
    end
    tick;
    set_cmd(1, 0, 0, 0, 16'h0, 16'h0);
    @(negedge Clock);
    total++;
    if (rvalid !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid got=%b want=00", rvalid); end
    tick;
    @(negedge Clock);
    total++;
    if (rvalid !== 2'b10 || rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL raw_read got rv=%b rd=%h want rv=10 rd=beef", rvalid, rdata);
    end
    tick;
  endtask

  task automatic test_lock_hold;
    logic [NREQ-1:0] want [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset;
    set_cmd(1, 1, 0, 0, 16'h0070, 16'h0);
    for (int c = 0; c < 4; c++) begin
      set_cmd(0, 1, (c < 2), 1, 16'h0080 + 16'(c), 16'h2000 + 16'(c));
      @(negedge Clock);
      total++;
      if (gnt !== want[c]) begin bad++; $display("FAIL lock_hold c=%0d got=%b want=%b", c, gnt, want[c]); end
      tick;
    end
  endtask

  task automatic test_watchdog;
    logic [NREQ-1:0] want [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                    2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset;
    set_cmd(0, 1, 1, 0, 16'h0090, 16'h0);
    set_cmd(1, 1, 0, 0, 16'h00A0, 16'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      total++;
      if (gnt !== want[c]) begin bad++; $display("FAIL watchdog c=%0d got=%b want=%b", c, gnt, want[c]); end
      tick;
    end
  endtask

  task automatic test_withdraw_idle;
    do_reset;
    set_cmd(0, 1, 0, 1, 16'h0123, 16'h4567);
    set_cmd(1, 1, 0, 0, 16'h0200, 16'h0);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL wd_first got=%b want=01", gnt); end
    tick;
    set_cmd(0, 0, 0, 0, 16'h0, 16'h0);
    set_cmd(1, 0, 0, 0, 16'h0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      total++;
      if (gnt !== 2'b00) begin bad++; $display("FAIL wd_idle_gnt c=%0d got=%b want=00", c, gnt); end
      total++;
      if (mem_wr !== (c == 0) || mem_addr !== 16'h0123) begin
        bad++;
        $display("FAIL wd_idle_mem c=%0d got wr=%b addr=%h want wr=%b addr=0123", c, mem_wr, mem_addr, (c == 0));
      end
      tick;
    end
    set_cmd(0, 1, 0, 0, 16'h0300, 16'h0);
    set_cmd(1, 1, 0, 0, 16'h0310, 16'h0);
    @(negedge Clock);
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL wd_ptr_kept got=%b want=10", gnt); end
    tick;
  endtask

  task automatic test_random;
    bit              pend [NREQ];
    logic            c_we [NREQ];
    logic [AW-1:0]   c_a  [NREQ];
    logic [DW-1:0]   c_d  [NREQ];
    logic [DW-1:0]   shadow [int];
    int              q_due[$];
    int              q_m[$];
    logic [DW-1:0]   q_d[$];
    int              m_ptr, m_owner, m_grants, m_nolock, g;
    bit              m_locked;
    logic [NREQ-1:0] eg, er, lk;
    logic [DW-1:0]   ed, rv;

    do_reset;
    for (int m = 0; m < NREQ; m++) pend[m] = 0;
    m_ptr = 0; m_owner = 0; m_grants = 0; m_nolock = -1; m_locked = 0;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < NREQ; m++) begin
        if (!pend[m]) begin
          if (c < 594 && $urandom_range(2) != 0) begin
            pend[m] = 1;
            c_we[m] = 1'($urandom_range(1));
            c_a[m]  = 16'h0200 + 16'($urandom_range(7));
            c_d[m]  = 16'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          pend[m] = 0;
        end
        set_cmd(m, pend[m], (c < 594) && ($urandom_range(3) == 0), pend[m] ? c_we[m] : 1'b0,
                pend[m] ? c_a[m] : 16'h0, pend[m] ? c_d[m] : 16'h0);
      end
      @(negedge Clock);

      g = -1;
      if (m_locked) begin
        if (pend[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      eg = (g >= 0) ? NREQ'(1) << g : '0;
      total++;
      if (gnt !== eg) begin bad++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, gnt, eg); end

      er = '0; ed = '0;
      if (q_due.size() > 0 && q_due[0] == c) begin
        er = NREQ'(1) << q_m[0];
        ed = q_d[0];
        void'(q_due.pop_front()); void'(q_m.pop_front()); void'(q_d.pop_front());
      end
      total++;
      if (rvalid !== er || (er != '0 && rdata !== ed)) begin
        bad++;
        $display("FAIL rand_read c=%0d got rv=%b rd=%h want rv=%b rd=%h", c, rvalid, rdata, er, ed);
      end

      lk = lock;
      if (m_nolock >= 0) lk[m_nolock] = 1'b0;
      m_nolock = -1;
      if (m_locked) begin
        if (g >= 0) begin
          m_grants++;
          if (!lk[m_owner] || m_grants == MAX_LOCK) begin
            if (lk[m_owner]) m_nolock = m_owner;
            m_locked = 0;
            m_ptr    = (m_owner + 1) % NREQ;
          end
        end else if (!lk[m_owner]) begin
          m_locked = 0;
          m_ptr    = (m_owner + 1) % NREQ;
        end
      end else if (g >= 0) begin
        if (lk[g]) begin
          m_locked = 1; m_owner = g; m_grants = 1;
        end else begin
          m_ptr = (g + 1) % NREQ;
        end
      end

      if (g >= 0) begin
        if (c_we[g]) begin
          shadow[int'(c_a[g])] = c_d[g];
        end else begin
          rv = shadow.exists(int'(c_a[g])) ? shadow[int'(c_a[g])] : init_val(c_a[g]);
          q_due.push_back(c + 2); q_m.push_back(g); q_d.push_back(rv);
        end
        pend[g] = 0;
      end
      tick;
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = init_val(AW'(a));
    test_reset;
    test_fairness;
    test_write_then_read;
    test_lock_hold;
    test_watchdog;
    test_withdraw_idle;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
